uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART TX FIFO push port (tx_push / tx_push_data / tx_full) between several message generators: watch, stopwatch, ultrasonic and DHT11 reporters.
- Grants the port to one requester per frame, round-robin. The grant is held until that requester's last byte, so frames never interleave on the line.
- A stall watchdog revokes the grant if a granted requester goes silent mid-frame.
- Sits between the per-sensor ASCII frame generators and uart_fifo.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1_000_000, idle-stall cycles tolerated while granted before abort (at least 2).
- TO_W, $clog2(TIMEOUT+1), width of the watchdog counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester: byte on req_data is valid
- req_data  in  8*N_REQ  per-requester byte; slice i = [8*i+7:8*i]
- req_last  in  N_REQ  per-requester: current byte ends the frame
- req_ready  out  N_REQ  per-requester: byte accepted this cycle (combinational)
- tx_full  in  1  TX FIFO full flag
- tx_push  out  1  registered push strobe to TX FIFO
- tx_push_data  out  8  registered push byte
- grant  out  N_REQ  one-hot current owner; 0 when idle
- busy  out  1  high while in state GRANT
- abort  out  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state=IDLE, grant=0, rr_ptr=N_REQ-1, tx_push=0, tx_push_data=0, abort=0, watchdog counter=0.
  - A partially pushed frame is not completed.
  - req_ready=0 while rst is asserted.
- States: IDLE and GRANT.
- IDLE:
  - req_ready=0.
  - If req_valid is nonzero, pick the first set bit searching upward from rr_ptr+1 (mod N_REQ).
  - Next cycle: grant=onehot(pick), state=GRANT, watchdog=0.
  - No byte is accepted in the selection cycle.
- GRANT, owner g:
  - req_ready[g] = req_valid[g] & ~tx_full & ~tx_push. All other ready bits are 0.
  - The ~tx_push term covers the FIFO's one-cycle full-flag update delay. Maximum throughput is therefore one byte per 2 cycles, which is ample for UART.
  - Transfer = req_valid[g] & req_ready[g]. Next cycle: tx_push=1, tx_push_data=req_data slice g. Push latency is 1 cycle.
  - Transfer with req_last[g]=1: next cycle state=IDLE, grant=0, rr_ptr=g.
    - A new arbitration can occur in the cycle after that.
    - Minimum gap between frames from different requesters is 1 idle cycle.
- tx_push is 0 in every cycle not following a transfer.
- Watchdog:
  - In GRANT, the counter increments each cycle req_valid[g]=0. It resets to 0 on any transfer.
  - Cycles stalled only by tx_full do not count (counter holds).
  - Counter reaching TIMEOUT: next cycle abort=1 for one cycle, state=IDLE, grant=0, rr_ptr=g.
  - No filler byte is pushed.
- Requests from non-owners during GRANT are ignored; they wait and are not lost if held.
- req_valid[g] dropping mid-frame is legal. It only feeds the watchdog.
- Simultaneous requests: the round-robin order guarantees each requester waits at most N_REQ-1 frames.
- tx_full stuck high: the owner is held indefinitely (no abort). This is intended back-pressure.
- Requester contract: req_data, req_last and req_valid are held stable until accepted.

Decomposition:
- Package uart_arb_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Default N_REQ, default TIMEOUT.
  - Requester index constants REQ_WATCH=0, REQ_STOPWATCH=1, REQ_SONIC=2, REQ_DHT11=3.
- Sub-module rr_pick (combinational): inputs req[N_REQ-1:0] and ptr; outputs onehot pick and valid. Instantiated once; tested standalone.

Test Plan:
- Single frame: N_REQ=4, req 1 sends "AB" then last byte 0x0D, tx_full=0 -> grant=0010 one cycle after request; tx_push pulses carry 0x41, 0x42, 0x0D, spaced 2 cycles apart; grant=0 after 0x0D; abort never asserted.
- Round-robin: reqs 0, 2, 3 all valid with 2-byte frames, rr_ptr=3 after reset -> frame order 0, 2, 3, then 0 again if still requesting; no interleaved bytes on tx_push.
- Back-pressure: tx_full=1 for 10 cycles mid-frame of req 3 -> no tx_push and req_ready=0 during that window; watchdog holds; frame resumes with the correct next byte and no duplication or loss.
- Watchdog: TIMEOUT=16; req 2 sends 1 non-last byte then drops req_valid -> abort pulses exactly 17 cycles after that byte's transfer cycle (16 stall cycles, then the 1-cycle abort register); grant=0; pending req 3 is granted next.
- Reset mid-frame: assert rst while req 0 is 3 bytes into a 9-byte frame -> tx_push, grant and busy go 0 immediately; after release, the first arbitration picks req 0 (rr_ptr=3).
- Non-owner hold: req 1 granted; req 0 asserts valid throughout -> req_ready[0]=0 until req 1's last byte; req 0 is granted 1 cycle after that frame ends.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART TX push-port arbiter
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 1_000_000;

  localparam int REQ_WATCH     = 0;
  localparam int REQ_STOPWATCH = 1;
  localparam int REQ_SONIC     = 2;
  localparam int REQ_DHT11     = 3;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request above ptr, wrapping
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_src;

  // Requests strictly above ptr win; otherwise wrap to the lowest request overall.
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_hi[i] = req[i] & (PTR_W'(i) > ptr);
    end
    w_src = (w_hi != '0) ? w_hi : req;
    pick  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-granular round-robin arbiter for the UART TX FIFO push port
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               tx_full,
  output logic               tx_push,
  output logic [7:0]         tx_push_data,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               abort
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic             r_push, w_push_nxt;
  logic [7:0]       r_push_data, w_push_data_nxt;
  logic             r_abort, w_abort_nxt;
  logic [TO_W-1:0]  r_wd, w_wd_nxt;

  logic [N_REQ-1:0] w_pick;
  logic             w_pick_valid;
  logic [PTR_W-1:0] w_owner;
  logic [7:0]       w_own_data;
  logic             w_own_valid;
  logic             w_own_last;
  logic             w_xfer;

  rr_pick #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_rr_pick (
    .req  (req_valid),
    .ptr  (r_rr_ptr),
    .pick (w_pick),
    .valid(w_pick_valid)
  );

  always_comb begin
    w_owner    = '0;
    w_own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_owner    = PTR_W'(i);
        w_own_data = req_data[8*i +: 8];
      end
    end
  end

  assign w_own_valid = |(req_valid & r_grant);
  assign w_own_last  = |(req_last & r_grant);
  // The ~r_push term hides the FIFO's one-cycle lag in updating tx_full.
  assign w_xfer      = (r_state == ST_GRANT) & w_own_valid & ~tx_full & ~r_push;
  assign req_ready   = ((r_state == ST_GRANT) && !rst && !tx_full && !r_push) ?
                       (req_valid & r_grant) : '0;

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_push_nxt      = 1'b0;
    w_push_data_nxt = r_push_data;
    w_abort_nxt     = 1'b0;
    w_wd_nxt        = r_wd;
    case (r_state)
      ST_IDLE: begin
        w_wd_nxt = '0;
        if (w_pick_valid) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_pick;
        end
      end
      ST_GRANT: begin
        if (w_xfer) begin
          w_push_nxt      = 1'b1;
          w_push_data_nxt = w_own_data;
          w_wd_nxt        = '0;
          if (w_own_last) begin
            w_state_nxt  = ST_IDLE;
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = w_owner;
          end
        end else if (!w_own_valid) begin
          // Only a silent owner ages the watchdog; tx_full stalls leave it untouched.
          if (r_wd == TO_W'(TIMEOUT - 1)) begin
            w_abort_nxt  = 1'b1;
            w_state_nxt  = ST_IDLE;
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = w_owner;
            w_wd_nxt     = '0;
          end else begin
            w_wd_nxt = r_wd + TO_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= PTR_W'(N_REQ - 1);
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_abort     <= 1'b0;
      r_wd        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_push      <= w_push_nxt;
      r_push_data <= w_push_data_nxt;
      r_abort     <= w_abort_nxt;
      r_wd        <= w_wd_nxt;
    end
  end

  assign grant        = r_grant;
  assign busy         = (r_state == ST_GRANT);
  assign tx_push      = r_push;
  assign tx_push_data = r_push_data;
  assign abort        = r_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_full;
  logic           tx_push;
  logic [7:0]     tx_push_data;
  logic [N-1:0]   grant;
  logic           busy;
  logic           abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_full(tx_full), .tx_push(tx_push), .tx_push_data(tx_push_data),
    .grant(grant), .busy(busy), .abort(abort)
  );

  logic [8:0] fq [N][$];
  bit         mute [N];
  bit         drop_after [N];
  bit         acc [N];
  int         xfer_cyc [N];
  logic [7:0] exp_q [$];
  int         push_cyc [$];
  logic [8:0] bfm_head;
  logic [7:0] exp_b;
  int cyc = 0, n_pass = 0, n_total = 0;
  int abort_cnt = 0, abort_cyc = -1, bad_ready = 0;
  int n, p0, p1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endfunction

  task automatic add(input int i, input logic [7:0] b, input bit last);
    fq[i].push_back({last, b});
    exp_q.push_back(b);
  endtask

  task automatic nwait();
    @(negedge clk); #1;
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string name);
    int k = 0;
    while (grant !== g && k < 200) begin nwait(); k++; end
    chk(name, grant, g);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin nwait(); k++; end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_pushes(input int target, input string name);
    int k = 0;
    while (push_cyc.size() < target && k < 200) begin nwait(); k++; end
    chk(name, push_cyc.size(), target);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Requester models plus output monitor: sample at negedge, drive #1 after posedge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (req_ready != '0) bad_ready++;
      end else begin
        if (tx_push) begin
          push_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_push: got 0x%0h expected no push", tx_push_data);
          end else begin
            exp_b = exp_q.pop_front();
            chk("push_data", tx_push_data, exp_b);
          end
        end
        if (abort) begin abort_cnt++; abort_cyc = cyc; end
        if ((req_ready & ~grant) != '0) bad_ready++;
        if (tx_full && req_ready != '0) bad_ready++;
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) begin acc[i] = 1'b1; xfer_cyc[i] = cyc; end
        end
      end
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          acc[i] = 1'b0;
          if (fq[i].size() > 0) void'(fq[i].pop_front());
          if (drop_after[i]) begin mute[i] = 1'b1; drop_after[i] = 1'b0; end
        end
        if (fq[i].size() > 0 && !mute[i]) begin
          bfm_head            = fq[i][0];
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = bfm_head[7:0];
          req_last[i]         = bfm_head[8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'h00;
          req_last[i]         = 1'b0;
        end
      end
    end
  end

  initial begin
    tx_full = 1'b0;
    nwait();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_push", tx_push, 0);
    chk("rst_push_data", tx_push_data, 0);
    chk("rst_abort", abort, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single frame from requester 1: "AB\r"
    add(1, 8'h41, 0); add(1, 8'h42, 0); add(1, 8'h0D, 1);
    n = 0;
    while (!req_valid[1] && n < 20) begin nwait(); n++; end
    chk("sf_req_seen", req_valid[1], 1);
    chk("sf_grant_sel_cycle", grant, 0);
    nwait();
    chk("sf_grant", grant, 4'b0010);
    p0 = push_cyc.size() - 0;
    wait_drain("sf_drain");
    chk("sf_grant_after", grant, 0);
    chk("sf_push_count", push_cyc.size(), 3);
    if (push_cyc.size() >= 3) begin
      chk("sf_gap1", push_cyc[1] - push_cyc[0], 2);
      chk("sf_gap2", push_cyc[2] - push_cyc[1], 2);
    end

    // Round-robin 0,2,3 then 0 again, pointer freshly reset to 3
    do_reset();
    add(0, 8'h01, 0); add(0, 8'h02, 1);
    add(2, 8'h21, 0); add(2, 8'h22, 1);
    add(3, 8'h31, 0); add(3, 8'h32, 1);
    add(0, 8'h03, 0); add(0, 8'h04, 1);
    wait_drain("rr_drain");

    // Non-owner requester 0 holds valid while 1 owns the port
    add(1, 8'h51, 0); add(1, 8'h52, 0); add(1, 8'h53, 1);
    wait_grant(4'b0010, "no_grant1");
    add(0, 8'h61, 1);
    n = 0;
    while (grant != '0 && n < 100) begin nwait(); n++; end
    chk("no_frame_end", grant, 0);
    nwait();
    chk("no_grant0_next", grant, 4'b0001);
    wait_drain("no_drain");

    // Back-pressure on requester 3 mid-frame, longer than the watchdog limit
    p0 = push_cyc.size();
    add(3, 8'h71, 0); add(3, 8'h72, 0); add(3, 8'h73, 0); add(3, 8'h74, 1);
    wait_pushes(p0 + 2, "bp_first2");
    @(posedge clk); #1 tx_full = 1'b1;
    p1 = push_cyc.size();
    repeat (20) nwait();
    chk("bp_no_push", push_cyc.size() - p1, 0);
    chk("bp_grant_held", grant, 4'b1000);
    chk("bp_no_abort", abort_cnt, 0);
    @(posedge clk); #1 tx_full = 1'b0;
    wait_drain("bp_drain");

    // Watchdog: requester 2 goes silent after one byte, 3 waiting
    drop_after[2] = 1'b1;
    add(2, 8'h81, 0);
    fq[2].push_back({1'b1, 8'h82});
    wait_grant(4'b0100, "wd_grant2");
    add(3, 8'h91, 1);
    n = 0;
    while (abort_cnt == 0 && n < 100) begin nwait(); n++; end
    chk("wd_abort_seen", abort_cnt, 1);
    chk("wd_abort_delay", abort_cyc - xfer_cyc[2], 17);
    chk("wd_grant_cleared", grant, 0);
    chk("wd_busy_cleared", busy, 0);
    nwait();
    chk("wd_abort_one_cycle", abort, 0);
    chk("wd_grant3", grant, 4'b1000);
    wait_drain("wd_drain");
    fq[2].delete();
    mute[2] = 1'b0;

    // Asynchronous reset three bytes into a nine-byte frame from requester 0
    p0 = push_cyc.size();
    for (int b = 0; b < 9; b++) add(0, 8'hA0 + 8'(b), (b == 8));
    wait_pushes(p0 + 3, "rm_three_pushed");
    #1 rst = 1'b1;
    #1;
    chk("rm_push", tx_push, 0);
    chk("rm_grant", grant, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ready", req_ready, 0);
    chk("rm_remaining", exp_q.size(), 6);
    exp_q.delete();
    fq[0].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    add(0, 8'hB0, 0); add(0, 8'hB1, 1);
    add(1, 8'hC0, 1);
    n = 0;
    while (grant == '0 && n < 50) begin nwait(); n++; end
    chk("rm_first_pick", grant, 4'b0001);
    wait_drain("rm_drain");

    chk("total_aborts", abort_cnt, 1);
    chk("ready_violations", bad_ready, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
